// File: rtl/posit_operand_decoder_if.sv
// Shared sign type plus the operand/decoded-field bundle between the issue stage and the mantissa adder.
// special_cnt is only present when DECODE_SPECIAL_CNT_EN is defined.
package common;
    typedef enum logic {POS = 1'b0, NEG = 1'b1} sign_t;
endpackage

interface posit_operand_decoder_if #(parameter int N = 8);
    import common::*;

    logic               in_valid;
    logic               in_ready;
    logic [N-1:0]       a_posit;
    logic [N-1:0]       b_posit;
    logic               out_valid;
    logic               out_ready;
    sign_t              a_sign;
    sign_t              b_sign;
    logic signed [7:0]  a_regime;
    logic signed [7:0]  b_regime;
    logic signed [7:0]  a_exponent;
    logic signed [7:0]  b_exponent;
    logic [7:0]         a_mantissa;
    logic [7:0]         b_mantissa;
    logic               a_zero;
    logic               a_nar;
    logic               b_zero;
    logic               b_nar;
`ifdef DECODE_SPECIAL_CNT_EN
    logic [15:0]        special_cnt;
`endif

    modport master (
        output in_valid, a_posit, b_posit, out_ready,
        input  in_ready, out_valid,
        input  a_sign, b_sign, a_regime, b_regime, a_exponent, b_exponent,
        input  a_mantissa, b_mantissa, a_zero, a_nar, b_zero, b_nar
`ifdef DECODE_SPECIAL_CNT_EN
        , input special_cnt
`endif
    );

    modport slave (
        input  in_valid, a_posit, b_posit, out_ready,
        output in_ready, out_valid,
        output a_sign, b_sign, a_regime, b_regime, a_exponent, b_exponent,
        output a_mantissa, b_mantissa, a_zero, a_nar, b_zero, b_nar
`ifdef DECODE_SPECIAL_CNT_EN
        , output special_cnt
`endif
    );
endinterface

// File: rtl/posit_operand_decoder.sv
// Posit operand-pair decoder (sign/regime/exponent/mantissa); DECODE_SPECIAL_CNT_EN adds special_cnt.
// Latency: pair presented in cycle c is on the outputs in cycle c+2; one pair per cycle sustained.
// Backpressure: elastic two-entry pipe, in_ready drops only when both stages hold data and out_ready=0.
module posit_operand_decoder #(
    parameter int N  = 8,
    parameter int ES = 1
) (
    input  logic clk,
    input  logic rst_n,
    posit_operand_decoder_if.slave io
);
    import common::*;

    typedef struct packed {
        sign_t        sign;
        logic [N-1:0] mag;
        logic [2:0]   run;
        logic         pol;
        logic         zero;
        logic         nar;
    } s1_t;

    typedef struct packed {
        sign_t             sign;
        logic signed [7:0] regime;
        logic signed [7:0] exponent;
        logic [7:0]        mantissa;
        logic              zero;
        logic              nar;
    } dec_t;

    function automatic s1_t stage1(input logic [N-1:0] p);
        s1_t  s;
        logic more;
        s.sign = p[N-1] ? NEG : POS;
        s.mag  = p[N-1] ? (~p + N'(1)) : p;
        s.zero = (p == '0);
        s.nar  = (p == {1'b1, {(N-1){1'b0}}});
        s.pol  = s.mag[N-2];
        s.run  = 3'd1;
        more   = 1'b1;
        for (int i = N - 3; i >= 0; i--) begin
            if (more && (s.mag[i] == s.pol)) s.run = s.run + 3'd1;
            else                             more  = 1'b0;
        end
        return s;
    endfunction

    // Shifting past the sign, run and terminator leaves exponent then fraction
    // at the top; truncated fields naturally read as zeros.
    function automatic dec_t stage2(input s1_t s);
        dec_t       d;
        logic [3:0] drop;
        logic [7:0] rem;
        logic [7:0] frac;
        drop       = {1'b0, s.run} + 4'd2;
        rem        = s.mag << drop;
        frac       = rem << ES;
        d.sign     = s.sign;
        d.regime   = s.pol ? ($signed({5'd0, s.run}) - 8'sd1) : -$signed({5'd0, s.run});
        d.exponent = $signed(rem >> (8 - ES));
        d.mantissa = 8'h80 | (frac >> 1);
        d.zero     = 1'b0;
        d.nar      = 1'b0;
        if (s.zero || s.nar) begin
            d      = '0;
            d.zero = s.zero;
            d.nar  = s.nar;
        end
        return d;
    endfunction

    logic s1_vld, s2_vld;
    s1_t  s1_a, s1_b;
    dec_t s2_a, s2_b;
    logic s1_adv, s2_adv;

    assign s2_adv      = !s2_vld || io.out_ready;
    assign s1_adv      = !s1_vld || s2_adv;
    assign io.in_ready = s1_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_a   <= '0;
            s1_b   <= '0;
            s2_vld <= 1'b0;
            s2_a   <= '0;
            s2_b   <= '0;
        end else begin
            if (s1_adv) begin
                s1_vld <= io.in_valid;
                if (io.in_valid) begin
                    s1_a <= stage1(io.a_posit);
                    s1_b <= stage1(io.b_posit);
                end
            end
            if (s2_adv) begin
                s2_vld <= s1_vld;
                if (s1_vld) begin
                    s2_a <= stage2(s1_a);
                    s2_b <= stage2(s1_b);
                end
            end
        end
    end

    assign io.out_valid  = s2_vld;
    assign io.a_sign     = s2_a.sign;
    assign io.a_regime   = s2_a.regime;
    assign io.a_exponent = s2_a.exponent;
    assign io.a_mantissa = s2_a.mantissa;
    assign io.a_zero     = s2_a.zero;
    assign io.a_nar      = s2_a.nar;
    assign io.b_sign     = s2_b.sign;
    assign io.b_regime   = s2_b.regime;
    assign io.b_exponent = s2_b.exponent;
    assign io.b_mantissa = s2_b.mantissa;
    assign io.b_zero     = s2_b.zero;
    assign io.b_nar      = s2_b.nar;

`ifdef DECODE_SPECIAL_CNT_EN
    logic [15:0] special_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            special_cnt <= 16'd0;
        end else if (s2_vld && io.out_ready && (s2_a.zero || s2_a.nar || s2_b.zero || s2_b.nar)
                     && (special_cnt != 16'hFFFF)) begin
            special_cnt <= special_cnt + 16'd1;
        end
    end
    assign io.special_cnt = special_cnt;
`endif
endmodule

// File: tb/tb_posit_operand_decoder.sv
// Bench for posit_operand_decoder: bit-walking posit model + scoreboard, directed vectors with literal expectations.
module tb_posit_operand_decoder;
    import common::*;

    localparam int ES = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    posit_operand_decoder_if #(.N(8)) io();

    posit_operand_decoder #(.N(8), .ES(ES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    typedef struct {
        int sign; int regime; int exponent; int mantissa; int zero; int nar;
    } exp_t;
    typedef struct { exp_t a; exp_t b; } pair_t;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    pair_t q[$];
    int    xfer_cyc[$];
    logic  prev_stall = 1'b0;
    logic  saw_full = 1'b0;
    int    spec_exp = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, req, req, cyc);
        end
    endtask

    // Reads the posit left to right: sign, run, terminator, exponent bits, fraction.
    function automatic exp_t model(input logic [7:0] p);
        exp_t       e;
        logic [7:0] v;
        logic       first;
        int         i, r, ebits, f, nf;
        e = '{0, 0, 0, 0, 0, 0};
        if (p == 8'h00) begin e.zero = 1; return e; end
        if (p == 8'h80) begin e.nar = 1;  return e; end
        e.sign = int'(p[7]);
        v = p[7] ? 8'(256 - int'(p)) : p;
        first = v[6];
        r = 0;
        i = 6;
        while (i >= 0 && v[i] == first) begin r++; i--; end
        if (i >= 0) i--;
        e.regime = first ? r - 1 : -r;
        ebits = 0;
        for (int k = 0; k < ES; k++) begin
            ebits = ebits * 2 + ((i >= 0) ? int'(v[i]) : 0);
            if (i >= 0) i--;
        end
        e.exponent = ebits;
        f = 0;
        nf = 0;
        while (i >= 0) begin f = f * 2 + int'(v[i]); nf++; i--; end
        e.mantissa = 128 + (f << (7 - nf));
        return e;
    endfunction

    task automatic cmp_side(input string s, input exp_t e, input sign_t sg, input logic signed [7:0] rg,
                            input logic signed [7:0] ex, input logic [7:0] m, input logic z, input logic n);
        chk({s, "_sign"}, int'(sg), e.sign);
        chk({s, "_regime"}, int'(rg), e.regime);
        chk({s, "_exponent"}, int'(ex), e.exponent);
        chk({s, "_mantissa"}, int'(m), e.mantissa);
        chk({s, "_zero"}, int'(z), e.zero);
        chk({s, "_nar"}, int'(n), e.nar);
    endtask

    always @(posedge clk) cyc++;

    // Monitor: inputs change just after posedge, so negedge values are what the next edge samples.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            prev_stall = 1'b0;
            spec_exp = 0;
        end else begin
            chk("in_ready", int'(io.in_ready), int'(q.size() < 2 || io.out_ready));
            if (q.size() == 2 && !io.out_ready && !io.in_ready) saw_full = 1'b1;
            if (prev_stall) chk("hold_valid", int'(io.out_valid), 1);
`ifdef DECODE_SPECIAL_CNT_EN
            chk("special_cnt", int'(io.special_cnt), spec_exp);
`endif
            if (io.out_valid) begin
                if (q.size() == 0) begin
                    chk("out_valid_unexpected", int'(io.out_valid), 0);
                end else begin
                    cmp_side("a", q[0].a, io.a_sign, io.a_regime, io.a_exponent, io.a_mantissa, io.a_zero, io.a_nar);
                    cmp_side("b", q[0].b, io.b_sign, io.b_regime, io.b_exponent, io.b_mantissa, io.b_zero, io.b_nar);
                    if (io.out_ready) begin
                        if ((q[0].a.zero | q[0].a.nar | q[0].b.zero | q[0].b.nar) != 0 && spec_exp < 65535)
                            spec_exp++;
                        void'(q.pop_front());
                        xfer_cyc.push_back(cyc);
                    end
                end
            end
            prev_stall = io.out_valid && !io.out_ready;
            if (io.in_valid && io.in_ready) q.push_back('{model(io.a_posit), model(io.b_posit)});
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b);
        logic ok;
        ok = 1'b0;
        io.in_valid = 1'b1;
        io.a_posit = a;
        io.b_posit = b;
        for (int t = 0; t < 60 && !ok; t++) begin
            @(negedge clk);
            ok = io.in_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) chk("send_timeout", int'(ok), 1);
        io.in_valid = 1'b0;
    endtask

    // Called right after the accepting edge with an otherwise empty pipe.
    task automatic lat_check(input string name);
        chk({name, "_early"}, int'(io.out_valid), 0);
        @(posedge clk);
        #1;
        chk({name, "_latency"}, int'(io.out_valid), 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int n0;
        exp_t e;
        io.in_valid = 1'b0;
        io.a_posit = 8'h00;
        io.b_posit = 8'h00;
        io.out_ready = 1'b1;

        e = model(8'h48);
        chk("model_48_mant", e.mantissa, 8'hC0);
        chk("model_48_regime", e.regime, 0);
        e = model(8'h50);
        chk("model_50_exp", e.exponent, 1);
        e = model(8'h01);
        chk("model_01_regime", e.regime, -6);
        e = model(8'h7F);
        chk("model_7f_regime", e.regime, 6);
        chk("model_7f_mant", e.mantissa, 8'h80);
        e = model(8'hC0);
        chk("model_c0_sign", e.sign, 1);

        idle(2);
        chk("rst_out_valid", int'(io.out_valid), 0);
        chk("rst_in_ready", int'(io.in_ready), 1);
        chk("rst_a_mantissa", int'(io.a_mantissa), 0);
        chk("rst_b_regime", int'(io.b_regime), 0);
        chk("rst_a_sign", int'(io.a_sign), int'(POS));
        chk("rst_b_nar", int'(io.b_nar), 0);
        rst_n = 1'b1;
        idle(1);

        send(8'h40, 8'h48);
        lat_check("basic");
        chk("basic_a_mant", int'(io.a_mantissa), 8'h80);
        chk("basic_b_mant", int'(io.b_mantissa), 8'hC0);
        idle(1);

        send(8'hC0, 8'h50);
        lat_check("negexp");
        chk("negexp_a_sign", int'(io.a_sign), int'(NEG));
        chk("negexp_b_exp", int'(io.b_exponent), 1);
        idle(1);

        send(8'h01, 8'h7F);
        lat_check("extreme");
        chk("extreme_a_regime", int'(io.a_regime), -6);
        chk("extreme_b_regime", int'(io.b_regime), 6);
        chk("extreme_b_mant", int'(io.b_mantissa), 8'h80);
        idle(1);

        send(8'h00, 8'h80);
        lat_check("special");
        chk("special_a_zero", int'(io.a_zero), 1);
        chk("special_b_nar", int'(io.b_nar), 1);
        chk("special_b_mant", int'(io.b_mantissa), 0);
        idle(2);
`ifdef DECODE_SPECIAL_CNT_EN
        chk("special_cnt_one", int'(io.special_cnt), 1);
`endif

        // Back-to-back stream with no stall must drain one pair per cycle.
        n0 = xfer_cyc.size();
        send(8'h20, 8'h9A);
        send(8'h6C, 8'hE3);
        send(8'h0F, 8'hFF);
        send(8'h81, 8'h3A);
        for (int t = 0; t < 40 && xfer_cyc.size() < n0 + 4; t++) @(posedge clk);
        #1;
        chk("tput_count", xfer_cyc.size(), n0 + 4);
        if (xfer_cyc.size() >= n0 + 4) chk("tput_span", xfer_cyc[n0 + 3] - xfer_cyc[n0], 3);
        idle(2);

        n0 = xfer_cyc.size();
        saw_full = 1'b0;
        fork
            begin
                send(8'h48, 8'h50);
                send(8'hB8, 8'h12);
                send(8'h7E, 8'h02);
                send(8'h00, 8'h44);
                send(8'h5A, 8'h80);
                send(8'hF0, 8'h33);
            end
            begin
                for (int t = 0; t < 45; t++) begin
                    io.out_ready = (t % 3 == 0);
                    @(posedge clk);
                    #1;
                end
            end
        join
        io.out_ready = 1'b1;
        for (int t = 0; t < 40 && xfer_cyc.size() < n0 + 6; t++) @(posedge clk);
        #1;
        chk("bp_count", xfer_cyc.size(), n0 + 6);
        chk("bp_saw_full", int'(saw_full), 1);
        idle(2);

        io.out_ready = 1'b0;
        send(8'h48, 8'h50);
        send(8'h01, 8'h7F);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(io.out_valid), 0);
        chk("midrst_a_mant", int'(io.a_mantissa), 0);
        chk("midrst_b_exp", int'(io.b_exponent), 0);
        chk("midrst_in_ready", int'(io.in_ready), 1);
        idle(2);
        rst_n = 1'b1;
        io.out_ready = 1'b1;
        idle(1);
        send(8'h40, 8'h40);
        lat_check("postrst");
        chk("postrst_a_mant", int'(io.a_mantissa), 8'h80);
        chk("postrst_b_regime", int'(io.b_regime), 0);
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish by 200000");
        $fatal(1, "timeout");
    end
endmodule
